instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the program memory.
- Owns the program counter and drives the memory's word address bus.
- Each cycle it latches the returned 32-bit instruction into an instruction register for the decode stage.
- Supports a decode/execute stall, a branch redirect with a single delay slot and an optional annul, and a halt on fetching the all-zero word.

Parameters:
- DATAWIDTH_BUS, 32, width of the address bus, data bus, PC and IR.
- RESET_ADDR, 32'h00000800, word address loaded into the PC at reset.
- COUNT_WIDTH, 16, width of the issued-instruction counter.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- RESET_InHigh  in  1  asynchronous, active-high reset.
- fetch_Stall_In  in  1  downstream cannot accept; hold all state.
- fetch_Redirect_In  in  1  taken branch resolved for the instruction currently in the IR.
- fetch_Annul_In  in  1  qualifies the redirect; the delay-slot instruction is squashed.
- fetch_Target_In  in  DATAWIDTH_BUS  branch target word address.
- BusDatos  in  DATAWIDTH_BUS  instruction word from program memory; combinational on BusDirecciones.
- BusDirecciones  out  DATAWIDTH_BUS  word address to program memory; equals PC.
- fetch_IR_Out  out  DATAWIDTH_BUS  latched instruction.
- fetch_IRPC_Out  out  DATAWIDTH_BUS  address of the latched instruction.
- fetch_IRValid_Out  out  1  fetch_IR_Out is a live instruction.
- fetch_Halted_Out  out  1  fetch stopped on the halt word.
- fetch_Count_Out  out  COUNT_WIDTH  number of valid instructions issued.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or while halted):
  - PC = RESET_ADDR; IR = 0; IRPC = 0; IRValid = 0; Halted = 0; Count = 0; state = FETCH.
- Addressing:
  - BusDirecciones = PC, combinational from the register.
  - PC counts in words: +1 per instruction, wrapping modulo 2^DATAWIDTH_BUS.
- States: FETCH and HALT.
- FETCH, fetch_Stall_In = 1:
  - PC, IR, IRPC, IRValid and Count all hold.
  - Redirect and annul inputs are ignored. Downstream keeps them asserted until stall drops.
- FETCH, fetch_Stall_In = 0, one fetch per cycle:
  - IR <= BusDatos.
  - IRPC <= PC.
  - PC <= fetch_Target_In if fetch_Redirect_In, else PC + 1.
  - IRValid <= NOT (fetch_Redirect_In AND fetch_Annul_In).
  - Count <= Count + 1 when the new IRValid = 1; Count wraps.
- Delay slot:
  - A redirect arrives while the branch sits in the IR, so the word fetched in that same cycle (branch address + 1) is the delay slot.
  - The delay slot is always latched. Annul only clears its valid bit.
  - The first target instruction appears in the IR on the following unstalled cycle.
  - fetch_Annul_In without fetch_Redirect_In has no effect.
- Halt detection, FETCH and unstalled, with BusDatos == 32'h0 and the word not annulled:
  - IR <= 0 and IRPC <= PC.
  - IRValid <= 0; Count does not increment.
  - PC holds at the halt address.
  - Halted <= 1; state -> HALT.
  - Halt wins over a simultaneous redirect: the redirect is discarded.
- Annulled zero word: it is squashed normally and does not halt.
- HALT:
  - All registers frozen; IRValid = 0; Halted = 1.
  - Stall, redirect and annul inputs are ignored.
  - Only reset exits this state.
- Latency:
  - Address to IR is 1 cycle.
  - Redirect to target in IR is 2 cycles, with the delay slot in between.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (FETCH = 1'b0, HALT = 1'b1);
  - HALT_WORD = 32'h00000000;
  - default RESET_ADDR;
  - opcode field positions later used by decode.
- No sub-module is needed. The optional issued-instruction counter may be split out as fetch_counter (enable, wrap); the top is otherwise a single always block plus output assigns.

Test Plan:
- Reset release with the team's program image loaded:
  - Cycle 0: BusDirecciones = 0x800.
  - After the first edge: IR = 0x82802001, IRPC = 0x800, IRValid = 1, Count = 1.
  - Next edge: IR = 0x84802001, IRPC = 0x801.
- Stall:
  - With IRPC = 0x802, hold fetch_Stall_In = 1 for 3 cycles: IR, IRPC, PC = 0x803 and Count unchanged.
  - Release stall: IRPC = 0x803 on the next edge.
- Redirect without annul:
  - With IRPC = 0x807 (branch word 0x0CBFFFFC), pulse Redirect with Target = 0x803.
  - Next IR is the delay slot at IRPC = 0x808 with IRValid = 1.
  - The edge after: IRPC = 0x803.
- Redirect with annul, same setup:
  - The 0x808 delay slot is latched with IRValid = 0 and Count does not increment.
  - The edge after: IRPC = 0x803 with IRValid = 1.
- Halt:
  - Run sequentially to 0x80E, which returns 0.
  - Halted = 1, IRValid = 0, BusDirecciones stays 0x80E.
  - Redirect pulses are ignored.
  - Reset returns to 0x800 with Halted = 0.
- Asynchronous reset mid-stall, asserted between clock edges:
  - Outputs clear immediately, without waiting for an edge.
  - BusDirecciones = 0x800 and Count = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, halt word, reset vector, opcode fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    // All-zero instruction word stops the fetch stage until reset.
    localparam logic [31:0] HALT_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0800;

    // Instruction field positions consumed by decode.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 21;
    localparam int RS1_MSB    = 20;
    localparam int RS1_LSB    = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/fetch_counter.sv
// Issued-instruction counter: increments by one on each enabled cycle and wraps.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none of its own; the parent gates the enable with stall/halt.
module fetch_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] count_d;
    logic [COUNT_WIDTH-1:0] count_q;

    // Next count: add one when enabled, natural wrap at 2^COUNT_WIDTH.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses program memory, latches one instruction per cycle into IR.
// Latency: address to IR 1 cycle; redirect to target in IR 2 cycles (delay slot in between).
// Backpressure: fetch_Stall_In freezes all state; halt word freezes everything until reset.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_ADDR    = DATAWIDTH_BUS'(DEFAULT_RESET_ADDR),
    parameter int                       COUNT_WIDTH   = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_InHigh,
    input  logic                     fetch_Stall_In,
    input  logic                     fetch_Redirect_In,
    input  logic                     fetch_Annul_In,
    input  logic [DATAWIDTH_BUS-1:0] fetch_Target_In,
    input  logic [DATAWIDTH_BUS-1:0] BusDatos,
    output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
    output logic [DATAWIDTH_BUS-1:0] fetch_IR_Out,
    output logic [DATAWIDTH_BUS-1:0] fetch_IRPC_Out,
    output logic                     fetch_IRValid_Out,
    output logic                     fetch_Halted_Out,
    output logic [COUNT_WIDTH-1:0]   fetch_Count_Out
);

    fetch_state_t             state_d, state_q;
    logic [DATAWIDTH_BUS-1:0] pc_d, pc_q;
    logic [DATAWIDTH_BUS-1:0] ir_d, ir_q;
    logic [DATAWIDTH_BUS-1:0] irpc_d, irpc_q;
    logic                     irvalid_d, irvalid_q;
    logic                     halted_d, halted_q;
    logic                     count_en;
    logic                     squash;
    logic                     is_halt_word;

    // Annul only matters when it qualifies a redirect.
    assign squash       = fetch_Redirect_In & fetch_Annul_In;
    assign is_halt_word = (BusDatos == DATAWIDTH_BUS'(HALT_WORD));

    // Next-state and datapath: one fetch per unstalled cycle; halt beats a simultaneous redirect.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        irpc_d    = irpc_q;
        irvalid_d = irvalid_q;
        halted_d  = halted_q;
        count_en  = 1'b0;
        case (state_q)
            FETCH: begin
                if (!fetch_Stall_In) begin
                    irpc_d = pc_q;
                    if (is_halt_word && !squash) begin
                        // PC stays on the halt address so the bus keeps showing it.
                        ir_d      = '0;
                        irvalid_d = 1'b0;
                        halted_d  = 1'b1;
                        state_d   = HALT;
                    end else begin
                        // Delay-slot word is always latched; annul just drops its valid bit.
                        ir_d      = BusDatos;
                        pc_d      = fetch_Redirect_In ? fetch_Target_In
                                                      : pc_q + DATAWIDTH_BUS'(1);
                        irvalid_d = !squash;
                        count_en  = !squash;
                    end
                end
            end
            HALT: begin
                irvalid_d = 1'b0;
                halted_d  = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and pipeline registers, asynchronously reset.
    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state_q   <= FETCH;
            pc_q      <= RESET_ADDR;
            ir_q      <= '0;
            irpc_q    <= '0;
            irvalid_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            irpc_q    <= irpc_d;
            irvalid_q <= irvalid_d;
            halted_q  <= halted_d;
        end
    end

    fetch_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_fetch_counter (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .en    (count_en),
        .count (fetch_Count_Out)
    );

    assign BusDirecciones    = pc_q;
    assign fetch_IR_Out      = ir_q;
    assign fetch_IRPC_Out    = irpc_q;
    assign fetch_IRValid_Out = irvalid_q;
    assign fetch_Halted_Out  = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational program-memory image.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises stall hold, redirect/annul delay slot, halt and async reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic        annul;
    logic [31:0] target;
    logic [31:0] bus_datos;
    logic [31:0] bus_dir;
    logic [31:0] ir;
    logic [31:0] irpc;
    logic        irvalid;
    logic        halted;
    logic [15:0] count;

    int checks;
    int failures;

    instr_fetch_unit #(
        .DATAWIDTH_BUS (32),
        .RESET_ADDR    (32'h0000_0800),
        .COUNT_WIDTH   (16)
    ) dut (
        .CLOCK_50          (clk),
        .RESET_InHigh      (rst),
        .fetch_Stall_In    (stall),
        .fetch_Redirect_In (redirect),
        .fetch_Annul_In    (annul),
        .fetch_Target_In   (target),
        .BusDatos          (bus_datos),
        .BusDirecciones    (bus_dir),
        .fetch_IR_Out      (ir),
        .fetch_IRPC_Out    (irpc),
        .fetch_IRValid_Out (irvalid),
        .fetch_Halted_Out  (halted),
        .fetch_Count_Out   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: 0x80E holds the halt word, everything else is non-zero.
    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'h800: prog = 32'h8280_2001;
            32'h801: prog = 32'h8480_2001;
            32'h802: prog = 32'h8680_2001;
            32'h803: prog = 32'h8880_2001;
            32'h804: prog = 32'h8A80_2001;
            32'h805: prog = 32'h8C80_2001;
            32'h806: prog = 32'h8E80_2001;
            32'h807: prog = 32'h0CBF_FFFC;
            32'h808: prog = 32'h9080_2001;
            32'h80E: prog = 32'h0000_0000;
            default: prog = 32'hA500_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign bus_datos = prog(bus_dir);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        annul    = 1'b0;
        target   = 32'h0;

        // Reset state.
        #3;
        chk("rst_addr",    bus_dir, 32'h800);
        chk("rst_valid",   {31'h0, irvalid}, 32'h0);
        chk("rst_halted",  {31'h0, halted}, 32'h0);
        chk("rst_count",   {16'h0, count}, 32'h0);
        step(1);
        rst = 1'b0;

        // First fetches.
        step(1);
        chk("f0_ir",    ir, 32'h8280_2001);
        chk("f0_irpc",  irpc, 32'h800);
        chk("f0_valid", {31'h0, irvalid}, 32'h1);
        chk("f0_count", {16'h0, count}, 32'h1);
        step(1);
        chk("f1_ir",    ir, 32'h8480_2001);
        chk("f1_irpc",  irpc, 32'h801);
        step(1);
        chk("f2_irpc",  irpc, 32'h802);

        // Stall holds everything for three cycles.
        stall = 1'b1;
        step(3);
        chk("stall_irpc",  irpc, 32'h802);
        chk("stall_ir",    ir, 32'h8680_2001);
        chk("stall_pc",    bus_dir, 32'h803);
        chk("stall_count", {16'h0, count}, 32'h3);
        stall = 1'b0;
        step(1);
        chk("unstall_irpc", irpc, 32'h803);
        chk("unstall_count", {16'h0, count}, 32'h4);

        // Redirect without annul: delay slot issued live.
        step(4);
        chk("br_ir", ir, 32'h0CBF_FFFC);
        chk("br_irpc", irpc, 32'h807);
        redirect = 1'b1;
        target   = 32'h803;
        step(1);
        redirect = 1'b0;
        chk("ds_irpc",  irpc, 32'h808);
        chk("ds_ir",    ir, 32'h9080_2001);
        chk("ds_valid", {31'h0, irvalid}, 32'h1);
        chk("ds_count", {16'h0, count}, 32'h9);
        chk("ds_pc",    bus_dir, 32'h803);
        step(1);
        chk("tgt_irpc", irpc, 32'h803);
        chk("tgt_count", {16'h0, count}, 32'hA);

        // Redirect with annul: delay slot latched but squashed.
        step(4);
        chk("br2_irpc", irpc, 32'h807);
        redirect = 1'b1;
        annul    = 1'b1;
        step(1);
        redirect = 1'b0;
        annul    = 1'b0;
        chk("ads_irpc",  irpc, 32'h808);
        chk("ads_valid", {31'h0, irvalid}, 32'h0);
        chk("ads_count", {16'h0, count}, 32'hE);
        step(1);
        chk("atgt_irpc",  irpc, 32'h803);
        chk("atgt_valid", {31'h0, irvalid}, 32'h1);
        chk("atgt_count", {16'h0, count}, 32'hF);

        // Annul alone does nothing.
        annul = 1'b1;
        step(1);
        annul = 1'b0;
        chk("lone_annul_valid", {31'h0, irvalid}, 32'h1);
        chk("lone_annul_irpc",  irpc, 32'h804);
        chk("lone_annul_count", {16'h0, count}, 32'h10);

        // Run to the halt word; a redirect on the halting cycle is discarded.
        step(9);
        chk("pre_halt_irpc", irpc, 32'h80D);
        chk("pre_halt_pc",   bus_dir, 32'h80E);
        redirect = 1'b1;
        target   = 32'h803;
        step(1);
        chk("halt_flag",  {31'h0, halted}, 32'h1);
        chk("halt_valid", {31'h0, irvalid}, 32'h0);
        chk("halt_pc",    bus_dir, 32'h80E);
        chk("halt_irpc",  irpc, 32'h80E);
        chk("halt_ir",    ir, 32'h0);
        chk("halt_count", {16'h0, count}, 32'h19);
        step(2);
        redirect = 1'b0;
        chk("halted_pc",    bus_dir, 32'h80E);
        chk("halted_flag",  {31'h0, halted}, 32'h1);
        chk("halted_count", {16'h0, count}, 32'h19);

        // Reset exits halt.
        #2 rst = 1'b1;
        #1;
        chk("unhalt_pc",     bus_dir, 32'h800);
        chk("unhalt_halted", {31'h0, halted}, 32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("restart_irpc",  irpc, 32'h800);
        chk("restart_count", {16'h0, count}, 32'h1);

        // Async reset mid-stall, between edges.
        step(1);
        stall = 1'b1;
        step(1);
        chk("mid_stall_irpc", irpc, 32'h801);
        #3 rst = 1'b1;
        #1;
        chk("async_pc",    bus_dir, 32'h800);
        chk("async_count", {16'h0, count}, 32'h0);
        chk("async_valid", {31'h0, irvalid}, 32'h0);
        chk("async_irpc",  irpc, 32'h0);
        chk("async_ir",    ir, 32'h0);
        stall = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
